// File: rtl/mem_req_sequencer_if.sv
// rtl/mem_req_sequencer_if.sv - CPU-side fetch and data request/response channels
interface mem_req_sequencer_if;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_resp_valid;
  logic        i_resp_ready;
  logic [31:0] i_resp_data;
  logic        i_resp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [1:0]  d_req_size;
  logic        d_req_sign;
  logic        d_resp_valid;
  logic        d_resp_ready;
  logic [31:0] d_resp_rdata;
  logic        d_resp_err;

  modport master (
    output i_req_valid, i_req_addr, i_resp_ready,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_size, d_req_sign, d_resp_ready,
    input  i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
    input  d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_resp_ready,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_size, d_req_sign, d_resp_ready,
    output i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
    output d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err
  );
endinterface

// File: rtl/mem_req_sequencer.sv
// rtl/mem_req_sequencer.sv - CPU front end for the Memory wrapper, one request in flight per port
module mem_req_sequencer #(
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_6000,
  parameter logic [31:0] DMEM_BASE  = 32'h0000_6000,
  parameter logic [31:0] DMEM_LIMIT = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                MEM_CLK,
  input  logic                RST,
  mem_req_sequencer_if.slave  cpu,
  output logic                MEM_RDEN1,
  output logic                MEM_RDEN2,
  output logic                MEM_WE2,
  output logic [13:0]         MEM_ADDR1,
  output logic [31:0]         MEM_ADDR2,
  output logic [31:0]         MEM_DIN2,
  output logic [1:0]          MEM_SIZE,
  output logic                MEM_SIGN,
  input  logic [31:0]         MEM_DOUT1,
  input  logic [31:0]         MEM_DOUT2,
  input  logic                memValid1,
  input  logic                memValid2,
  output logic                timeout_err
);
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      i_state_q, i_state_d;
  logic [13:0] i_addr_q, i_addr_d;
  logic [31:0] i_data_q, i_data_d;
  logic        i_err_q, i_err_d;

  state_e      d_state_q, d_state_d;
  logic        d_we_q, d_we_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [1:0]  d_size_q, d_size_d;
  logic        d_sign_q, d_sign_d;
  logic [31:0] d_data_q, d_data_d;
  logic        d_err_q, d_err_d;

  logic        i_legal, d_legal, d_aligned;
  logic        i_timeout, d_timeout;

  assign i_legal = (cpu.i_req_addr < IMEM_LIMIT) && (cpu.i_req_addr[1:0] == 2'b00);

  always_comb begin
    d_aligned = 1'b0;
    case (cpu.d_req_size)
      2'd0:    d_aligned = 1'b1;
      2'd1:    d_aligned = (cpu.d_req_addr[0] == 1'b0);
      2'd2:    d_aligned = (cpu.d_req_addr[1:0] == 2'b00);
      default: d_aligned = 1'b0;
    endcase
  end

  assign d_legal = (cpu.d_req_addr >= DMEM_BASE) && (cpu.d_req_addr < DMEM_LIMIT) && d_aligned;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    i_cnt_d   = '0;
    d_cnt_d   = '0;
    i_timeout = 1'b0;
    d_timeout = 1'b0;
    if (i_state_q == BUSY && !memValid1) begin
      if (i_cnt_q == CNT_LAST) i_timeout = 1'b1;
      else                     i_cnt_d   = i_cnt_q + 1'b1;
    end
    if (d_state_q == BUSY && !memValid2) begin
      if (d_cnt_q == CNT_LAST) d_timeout = 1'b1;
      else                     d_cnt_d   = d_cnt_q + 1'b1;
    end
    timeout_d = i_timeout || d_timeout;
  end

  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign i_timeout   = 1'b0;
  assign d_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    i_state_d = i_state_q;
    i_addr_d  = i_addr_q;
    i_data_d  = i_data_q;
    i_err_d   = i_err_q;
    case (i_state_q)
      IDLE: begin
        if (cpu.i_req_valid) begin
          i_addr_d = cpu.i_req_addr[15:2];
          if (i_legal) begin
            i_state_d = BUSY;
          end else begin
            i_state_d = RESP;
            i_data_d  = ERR_DATA;
            i_err_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        if (memValid1) begin
          i_state_d = RESP;
          i_data_d  = MEM_DOUT1;
          i_err_d   = 1'b0;
        end else if (i_timeout) begin
          i_state_d = RESP;
          i_data_d  = ERR_DATA;
          i_err_d   = 1'b1;
        end
      end
      RESP: begin
        if (cpu.i_resp_ready) i_state_d = IDLE;
      end
      default: i_state_d = IDLE;
    endcase
  end

  always_comb begin
    d_state_d = d_state_q;
    d_we_d    = d_we_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_size_d  = d_size_q;
    d_sign_d  = d_sign_q;
    d_data_d  = d_data_q;
    d_err_d   = d_err_q;
    case (d_state_q)
      IDLE: begin
        if (cpu.d_req_valid) begin
          d_we_d    = cpu.d_req_we;
          d_addr_d  = cpu.d_req_addr;
          d_wdata_d = cpu.d_req_wdata;
          d_size_d  = cpu.d_req_size;
          d_sign_d  = cpu.d_req_sign;
          if (d_legal) begin
            d_state_d = BUSY;
          end else begin
            d_state_d = RESP;
            d_data_d  = ERR_DATA;
            d_err_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        if (memValid2) begin
          d_state_d = RESP;
          d_data_d  = d_we_q ? 32'h0 : MEM_DOUT2;
          d_err_d   = 1'b0;
        end else if (d_timeout) begin
          d_state_d = RESP;
          d_data_d  = ERR_DATA;
          d_err_d   = 1'b1;
        end
      end
      RESP: begin
        if (cpu.d_resp_ready) d_state_d = IDLE;
      end
      default: d_state_d = IDLE;
    endcase
  end

  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      i_state_q <= IDLE;
      i_addr_q  <= '0;
      i_data_q  <= '0;
      i_err_q   <= 1'b0;
      d_state_q <= IDLE;
      d_we_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_size_q  <= '0;
      d_sign_q  <= 1'b0;
      d_data_q  <= '0;
      d_err_q   <= 1'b0;
    end else begin
      i_state_q <= i_state_d;
      i_addr_q  <= i_addr_d;
      i_data_q  <= i_data_d;
      i_err_q   <= i_err_d;
      d_state_q <= d_state_d;
      d_we_q    <= d_we_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      d_size_q  <= d_size_d;
      d_sign_q  <= d_sign_d;
      d_data_q  <= d_data_d;
      d_err_q   <= d_err_d;
    end
  end

  assign cpu.i_req_ready  = (i_state_q == IDLE) && !RST;
  assign cpu.i_resp_valid = (i_state_q == RESP);
  assign cpu.i_resp_data  = i_data_q;
  assign cpu.i_resp_err   = i_err_q;

  assign cpu.d_req_ready  = (d_state_q == IDLE) && !RST;
  assign cpu.d_resp_valid = (d_state_q == RESP);
  assign cpu.d_resp_rdata = d_data_q;
  assign cpu.d_resp_err   = d_err_q;

  assign MEM_RDEN1 = (i_state_q == BUSY);
  assign MEM_ADDR1 = i_addr_q;
  assign MEM_RDEN2 = (d_state_q == BUSY) && !d_we_q;
  assign MEM_WE2   = (d_state_q == BUSY) && d_we_q;
  assign MEM_ADDR2 = d_addr_q;
  assign MEM_DIN2  = d_wdata_q;
  assign MEM_SIZE  = d_size_q;
  assign MEM_SIGN  = d_sign_q;
endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb/tb_mem_req_sequencer.sv - directed and randomized bench for mem_req_sequencer
module tb_mem_req_sequencer;
  localparam logic [31:0] IMEM_LIMIT = 32'h0000_6000;
  localparam logic [31:0] DMEM_BASE  = 32'h0000_6000;
  localparam logic [31:0] DMEM_LIMIT = 32'h0001_0000;
  localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_RDEN1, MEM_RDEN2, MEM_WE2, MEM_SIGN, timeout_err;
  logic [13:0] MEM_ADDR1;
  logic [31:0] MEM_ADDR2, MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic [31:0] MEM_DOUT1 = '0;
  logic [31:0] MEM_DOUT2 = '0;
  logic        memValid1 = 1'b0;
  logic        memValid2 = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_req_sequencer_if cpu();

  mem_req_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .MEM_CLK(clk), .RST(rst), .cpu(cpu),
    .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2),
    .MEM_ADDR1(MEM_ADDR1), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT1(MEM_DOUT1), .MEM_DOUT2(MEM_DOUT2),
    .memValid1(memValid1), .memValid2(memValid2),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit i_legal_f(input logic [31:0] a);
    return (a < IMEM_LIMIT) && (a % 4 == 0);
  endfunction

  function automatic bit d_legal_f(input logic [31:0] a, input logic [1:0] sz);
    int align;
    if (sz == 2'd3) return 1'b0;
    align = 1 << sz;
    return (a >= DMEM_BASE) && (a < DMEM_LIMIT) && (a % align == 0);
  endfunction

  bit          m_i_out, m_i_wait, m_i_err;
  logic [13:0] m_i_addr;
  logic [31:0] m_i_data;
  int          m_i_cnt;
  bit          m_d_out, m_d_wait, m_d_we, m_d_sign, m_d_err;
  logic [31:0] m_d_addr, m_d_wdata, m_d_data;
  logic [1:0]  m_d_size;
  int          m_d_cnt;
  bit          m_to;

  always @(negedge clk) begin
    bit i_to, d_to;
    chk("i_req_ready", cpu.i_req_ready, !rst && !m_i_out);
    chk("d_req_ready", cpu.d_req_ready, !rst && !m_d_out);
    chk("MEM_RDEN1", MEM_RDEN1, m_i_out && m_i_wait);
    chk("MEM_RDEN2", MEM_RDEN2, m_d_out && m_d_wait && !m_d_we);
    chk("MEM_WE2", MEM_WE2, m_d_out && m_d_wait && m_d_we);
    chk("MEM_ADDR1", MEM_ADDR1, m_i_addr);
    chk("MEM_ADDR2", MEM_ADDR2, m_d_addr);
    chk("MEM_DIN2", MEM_DIN2, m_d_wdata);
    chk("MEM_SIZE", MEM_SIZE, m_d_size);
    chk("MEM_SIGN", MEM_SIGN, m_d_sign);
    chk("timeout_err", timeout_err, m_to);
    chk("i_resp_valid", cpu.i_resp_valid, m_i_out && !m_i_wait);
    chk("d_resp_valid", cpu.d_resp_valid, m_d_out && !m_d_wait);
    if (m_i_out && !m_i_wait) begin
      chk("i_resp_data", cpu.i_resp_data, m_i_data);
      chk("i_resp_err", cpu.i_resp_err, m_i_err);
    end
    if (m_d_out && !m_d_wait) begin
      chk("d_resp_rdata", cpu.d_resp_rdata, m_d_data);
      chk("d_resp_err", cpu.d_resp_err, m_d_err);
    end

    i_to = 1'b0;
    d_to = 1'b0;
    if (rst) begin
      m_i_out = 0; m_i_wait = 0; m_i_addr = '0;
      m_d_out = 0; m_d_wait = 0; m_d_addr = '0; m_d_wdata = '0; m_d_size = '0; m_d_sign = 0;
      m_d_we = 0;
    end else begin
      if (!m_i_out) begin
        if (cpu.i_req_valid) begin
          m_i_out  = 1;
          m_i_addr = cpu.i_req_addr[15:2];
          m_i_cnt  = 0;
          m_i_wait = i_legal_f(cpu.i_req_addr);
          if (!m_i_wait) begin m_i_data = ERR_DATA; m_i_err = 1; end
        end
      end else if (m_i_wait) begin
        if (memValid1) begin
          m_i_wait = 0; m_i_data = MEM_DOUT1; m_i_err = 0;
        end else begin
`ifdef MEM_TIMEOUT_EN
          m_i_cnt++;
          if (m_i_cnt == TO) begin m_i_wait = 0; m_i_data = ERR_DATA; m_i_err = 1; i_to = 1; end
`endif
        end
      end else if (cpu.i_resp_ready) begin
        m_i_out = 0;
      end

      if (!m_d_out) begin
        if (cpu.d_req_valid) begin
          m_d_out   = 1;
          m_d_we    = cpu.d_req_we;
          m_d_addr  = cpu.d_req_addr;
          m_d_wdata = cpu.d_req_wdata;
          m_d_size  = cpu.d_req_size;
          m_d_sign  = cpu.d_req_sign;
          m_d_cnt   = 0;
          m_d_wait  = d_legal_f(cpu.d_req_addr, cpu.d_req_size);
          if (!m_d_wait) begin m_d_data = ERR_DATA; m_d_err = 1; end
        end
      end else if (m_d_wait) begin
        if (memValid2) begin
          m_d_wait = 0; m_d_data = m_d_we ? 32'h0 : MEM_DOUT2; m_d_err = 0;
        end else begin
`ifdef MEM_TIMEOUT_EN
          m_d_cnt++;
          if (m_d_cnt == TO) begin m_d_wait = 0; m_d_data = ERR_DATA; m_d_err = 1; d_to = 1; end
`endif
        end
      end else if (cpu.d_resp_ready) begin
        m_d_out = 0;
      end
    end
    m_to = i_to || d_to;
  end

  function automatic logic [31:0] rand_iaddr();
    case ($urandom_range(0, 5))
      0:       return IMEM_LIMIT - 32'd4;
      1:       return IMEM_LIMIT + $urandom_range(0, 3);
      2:       return $urandom_range(0, 32'h5FFF);
      default: return $urandom_range(0, 32'h17FF) << 2;
    endcase
  endfunction

  function automatic logic [31:0] rand_daddr();
    case ($urandom_range(0, 6))
      0:       return DMEM_BASE - 32'd4;
      1:       return DMEM_LIMIT - 32'd4;
      2:       return DMEM_LIMIT + $urandom_range(0, 3);
      3:       return DMEM_BASE + $urandom_range(0, 32'h9FFF);
      default: return DMEM_BASE + ($urandom_range(0, 32'h27FF) << 2);
    endcase
  endfunction

  initial begin
    int n;
    cpu.i_req_valid = 0; cpu.i_req_addr = '0; cpu.i_resp_ready = 0;
    cpu.d_req_valid = 0; cpu.d_req_we = 0; cpu.d_req_addr = '0; cpu.d_req_wdata = '0;
    cpu.d_req_size = '0; cpu.d_req_sign = 0; cpu.d_resp_ready = 0;
    tick(); tick();
    chk("rst_i_ready", cpu.i_req_ready, 0);
    chk("rst_rden1", MEM_RDEN1, 0);
    chk("rst_addr2", MEM_ADDR2, 0);
    rst = 0;
    tick();
    chk("post_rst_i_ready", cpu.i_req_ready, 1);
    chk("post_rst_d_ready", cpu.d_req_ready, 1);

    cpu.i_req_valid = 1; cpu.i_req_addr = 32'h100;
    tick();
    cpu.i_req_valid = 0;
    chk("fetch_rden1", MEM_RDEN1, 1);
    chk("fetch_addr1", MEM_ADDR1, 32'h040);
    tick(); tick();
    memValid1 = 1; MEM_DOUT1 = 32'h0000_0013;
    tick();
    memValid1 = 0;
    chk("fetch_resp_valid", cpu.i_resp_valid, 1);
    chk("fetch_resp_data", cpu.i_resp_data, 32'h13);
    chk("fetch_resp_err", cpu.i_resp_err, 0);
    chk("fetch_rden1_off", MEM_RDEN1, 0);
    cpu.i_resp_ready = 1;
    tick();
    cpu.i_resp_ready = 0;
    chk("fetch_done", cpu.i_resp_valid, 0);

    cpu.d_req_valid = 1; cpu.d_req_we = 1; cpu.d_req_addr = 32'h6004;
    cpu.d_req_wdata = 32'hCAFE_F00D; cpu.d_req_size = 2'd2;
    tick();
    cpu.d_req_valid = 0;
    chk("store_we2", MEM_WE2, 1);
    chk("store_rden2", MEM_RDEN2, 0);
    chk("store_din2", MEM_DIN2, 32'hCAFE_F00D);
    tick(); tick();
    memValid2 = 1; MEM_DOUT2 = 32'h1234_5678;
    tick();
    memValid2 = 0;
    chk("store_resp_valid", cpu.d_resp_valid, 1);
    chk("store_rdata", cpu.d_resp_rdata, 0);
    chk("store_err", cpu.d_resp_err, 0);
    cpu.d_resp_ready = 1;
    tick();
    cpu.d_resp_ready = 0;

    cpu.i_req_valid = 1; cpu.i_req_addr = 32'h6000;
    cpu.d_req_valid = 1; cpu.d_req_we = 0; cpu.d_req_addr = 32'h6002; cpu.d_req_size = 2'd2;
    tick();
    cpu.i_req_valid = 0; cpu.d_req_valid = 0;
    chk("ill_rden1", MEM_RDEN1, 0);
    chk("ill_rden2", MEM_RDEN2, 0);
    chk("ill_we2", MEM_WE2, 0);
    chk("ill_i_err", cpu.i_resp_err, 1);
    chk("ill_i_data", cpu.i_resp_data, 32'hDEAD_BEEF);
    chk("ill_d_err", cpu.d_resp_err, 1);
    chk("ill_d_data", cpu.d_resp_rdata, 32'hDEAD_BEEF);
    cpu.i_resp_ready = 1; cpu.d_resp_ready = 1;
    tick();
    cpu.i_resp_ready = 0; cpu.d_resp_ready = 0;

    cpu.i_req_valid = 1; cpu.i_req_addr = 32'h200;
    cpu.d_req_valid = 1; cpu.d_req_we = 0; cpu.d_req_addr = 32'h7000; cpu.d_req_size = 2'd2;
    tick();
    cpu.i_req_valid = 0; cpu.d_req_valid = 0;
    chk("sim_rden1", MEM_RDEN1, 1);
    chk("sim_rden2", MEM_RDEN2, 1);
    memValid2 = 1; MEM_DOUT2 = 32'hA5A5_0001;
    tick();
    memValid2 = 0;
    chk("sim_i_pending", cpu.i_resp_valid, 0);
    for (int k = 0; k < 5; k++) begin
      memValid1 = (k == 1);
      MEM_DOUT1 = 32'h77;
      cpu.i_resp_ready = (k == 2);
      tick();
      chk("sim_d_hold_valid", cpu.d_resp_valid, 1);
      chk("sim_d_hold_data", cpu.d_resp_rdata, 32'hA5A5_0001);
      if (k == 1) chk("sim_i_data", cpu.i_resp_data, 32'h77);
    end
    memValid1 = 0; cpu.i_resp_ready = 0; cpu.d_resp_ready = 1;
    tick();
    cpu.d_resp_ready = 0;
    chk("sim_d_done", cpu.d_resp_valid, 0);

    cpu.i_req_valid = 1; cpu.i_req_addr = 32'h300;
    tick();
    cpu.i_req_valid = 0;
    chk("rstb_rden1", MEM_RDEN1, 1);
    rst = 1;
    tick();
    chk("rstb_rden1_off", MEM_RDEN1, 0);
    chk("rstb_no_resp", cpu.i_resp_valid, 0);
    rst = 0;
    tick();
    chk("rstb_ready", cpu.i_req_ready, 1);
    chk("rstb_no_resp2", cpu.i_resp_valid, 0);

`ifdef MEM_TIMEOUT_EN
    cpu.i_req_valid = 1; cpu.i_req_addr = 32'h400;
    tick();
    cpu.i_req_valid = 0;
    n = 0;
    while (!cpu.i_resp_valid && n < 20) begin tick(); n++; end
    chk("to_busy_cycles", n, 8);
    chk("to_pulse", timeout_err, 1);
    chk("to_err", cpu.i_resp_err, 1);
    chk("to_data", cpu.i_resp_data, 32'hDEAD_BEEF);
    cpu.i_resp_ready = 1;
    tick();
    cpu.i_resp_ready = 0;
    chk("to_pulse_end", timeout_err, 0);
`else
    cpu.i_req_valid = 1; cpu.i_req_addr = 32'h400;
    tick();
    cpu.i_req_valid = 0;
    n = 0;
    while (!cpu.i_resp_valid && n < 20) begin tick(); n++; end
    chk("wait_still_busy", MEM_RDEN1, 1);
    chk("wait_cycles", n, 20);
    memValid1 = 1; MEM_DOUT1 = 32'h55;
    tick();
    memValid1 = 0; cpu.i_resp_ready = 1;
    chk("wait_resp_data", cpu.i_resp_data, 32'h55);
    tick();
    cpu.i_resp_ready = 0;
`endif

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      cpu.i_req_valid  = $urandom_range(0, 1);
      cpu.i_req_addr   = rand_iaddr();
      cpu.i_resp_ready = ($urandom_range(0, 9) < 6);
      cpu.d_req_valid  = $urandom_range(0, 1);
      cpu.d_req_we     = $urandom_range(0, 1);
      cpu.d_req_addr   = rand_daddr();
      cpu.d_req_wdata  = $urandom;
      cpu.d_req_size   = 2'($urandom_range(0, 3));
      cpu.d_req_sign   = $urandom_range(0, 1);
      cpu.d_resp_ready = ($urandom_range(0, 9) < 6);
      memValid1 = ($urandom_range(0, 9) < 3);
      memValid2 = ($urandom_range(0, 9) < 3);
      MEM_DOUT1 = $urandom;
      MEM_DOUT2 = $urandom;
      tick();
    end

    rst = 0;
    cpu.i_req_valid = 0; cpu.d_req_valid = 0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
